scaler_coe_sched: RTL and testbench

- Per-line coefficient scheduler for the scaler's 4-tap cubic coefficient ROM.
- Runs a fractional phase accumulator over one destination line and drives the ROM address, one entry per output pixel.
- Emits a sideband stream aligned to the ROM's registered outputs. Each beat carries the number of source pixels the tap window must advance, plus a last flag.
- Sits between the line controller (start/done) and the filter datapath (valid/ready).

---
 rtl/user_pkg.sv | 25 ++
 rtl/scaler_coe_sched_if.sv | 32 +++
 rtl/scaler_phase_acc.sv | 82 ++++++++
 rtl/scaler_coe_sched.sv | 139 +++++++++++++
 tb/tb_scaler_coe_sched.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/user_pkg.sv
// rtl/user_pkg.sv - shared scaler defaults, CLOG2 helper and scheduler state encodings
//
// Purpose: constants shared by the coefficient scheduler, the coefficient ROM
// and the filter datapath, so that all three agree on ROM depth and step format.
// Ports: none (package).

`ifndef USER_PKG_CLOG2
`define USER_PKG_CLOG2
`define CLOG2(x) $clog2(x)
`endif

package user_pkg;

  localparam int COE_DEPTH_DEF  = 32;
  localparam int STEP_WIDTH_DEF = 16;
  localparam int FRAC_WIDTH_DEF = 12;
  localparam int LEN_WIDTH_DEF  = 12;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_RUN   = 2'd1,
    SCHED_FLUSH = 2'd2
  } sched_state_e;

endpackage

// File: rtl/scaler_coe_sched_if.sv
// rtl/scaler_coe_sched_if.sv - coefficient beat stream between scheduler and filter datapath
//
// Purpose: groups the ROM address and its sideband beat (valid/ready/adv/last).
// Ports (signals):
//   coe_addr    ROM address of the beat
//   coe_vld     beat valid, aligned with ROM data
//   coe_ready   datapath accepts the beat
//   coe_src_adv source pixels to advance after this beat
//   coe_last    final beat of the line

interface scaler_coe_sched_if
  import user_pkg::*;
#(
  parameter int AW    = $clog2(COE_DEPTH_DEF),
  parameter int ADV_W = STEP_WIDTH_DEF - FRAC_WIDTH_DEF + 1
);
  logic [AW-1:0]    coe_addr;
  logic             coe_vld;
  logic             coe_ready;
  logic [ADV_W-1:0] coe_src_adv;
  logic             coe_last;

  modport master (
    output coe_addr, coe_vld, coe_src_adv, coe_last,
    input  coe_ready
  );

  modport slave (
    input  coe_addr, coe_vld, coe_src_adv, coe_last,
    output coe_ready
  );
endinterface

// File: rtl/scaler_phase_acc.sv
// rtl/scaler_phase_acc.sv - fractional phase accumulator, carry-to-advance and issue counter
//
// Purpose: holds the latched line config, the fractional phase and the pixel
// counter; presents the ROM address, source advance and last flag for the
// pixel that would issue this cycle.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load_i      latch step/len, clear phase and counter
//   step_i      scale step to latch
//   len_i       destination pixel count to latch
//   issue_i     current pixel issues this cycle
//   addr_o      ROM address of the current pixel
//   adv_o       integer carry out of phase + step
//   last_o      current pixel is the last of the line

module scaler_phase_acc
  import user_pkg::*;
#(
  parameter int STEP_WIDTH = STEP_WIDTH_DEF,
  parameter int FRAC_WIDTH = FRAC_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int AW         = $clog2(COE_DEPTH_DEF),
  parameter int ADV_W      = STEP_WIDTH - FRAC_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [STEP_WIDTH-1:0] step_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  issue_i,
  output logic [AW-1:0]         addr_o,
  output logic [ADV_W-1:0]      adv_o,
  output logic                  last_o
);

  // One bit wider than the step so the integer carry is never lost.
  localparam int SUM_W = STEP_WIDTH + 1;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [FRAC_WIDTH-1:0] acc_q, acc_d;
  logic [SUM_W-1:0]      sum;

  assign sum    = SUM_W'(acc_q) + SUM_W'(step_q);
  assign addr_o = acc_q[FRAC_WIDTH-1 -: AW];
  assign adv_o  = sum[SUM_W-1:FRAC_WIDTH];
  // len_q=0 never reaches RUN, so the wrapped len_q-1 is never consulted.
  assign last_o = (cnt_q == (len_q - LEN_ONE));

  always_comb begin
    step_d = step_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    if (load_i) begin
      step_d = step_i;
      len_d  = len_i;
      cnt_d  = '0;
      acc_d  = '0;
    end else if (issue_i) begin
      cnt_d = cnt_q + LEN_ONE;
      acc_d = sum[FRAC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else begin
      step_q <= step_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/scaler_coe_sched.sv
// rtl/scaler_coe_sched.sv - per-line cubic coefficient ROM scheduler
//
// Purpose: walks the phase accumulator across one destination line, one ROM
// entry per output pixel, and emits a beat stream aligned one cycle after issue.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle pulse, latches config and begins a line (ignored when busy)
//   cfg_step     source/destination ratio, unsigned fixed point
//   cfg_dst_len  output pixels this line
//   busy         line in progress
//   done         one-cycle pulse after the last beat is accepted
//   coe          beat stream (master side)

module scaler_coe_sched
  import user_pkg::*;
#(
  parameter int COE_DEPTH  = COE_DEPTH_DEF,
  parameter int STEP_WIDTH = STEP_WIDTH_DEF,
  parameter int FRAC_WIDTH = FRAC_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [STEP_WIDTH-1:0] cfg_step,
  input  logic [LEN_WIDTH-1:0]  cfg_dst_len,
  output logic                  busy,
  output logic                  done,
  scaler_coe_sched_if.master    coe
);

  localparam int AW    = $clog2(COE_DEPTH);
  localparam int ADV_W = STEP_WIDTH - FRAC_WIDTH + 1;

  sched_state_e state_q, state_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic load, issue, accept;

  logic             vld_q, last_q;
  logic [AW-1:0]    addr_q;
  logic [ADV_W-1:0] adv_q;

  logic [AW-1:0]    pa_addr;
  logic [ADV_W-1:0] pa_adv;
  logic             pa_last;

  scaler_phase_acc #(
    .STEP_WIDTH (STEP_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .AW         (AW),
    .ADV_W      (ADV_W)
  ) u_phase_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .step_i  (cfg_step),
    .len_i   (cfg_dst_len),
    .issue_i (issue),
    .addr_o  (pa_addr),
    .adv_o   (pa_adv),
    .last_o  (pa_last)
  );

  assign accept = vld_q & coe.coe_ready;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    issue   = 1'b0;
    case (state_q)
      SCHED_IDLE: begin
        if (start) begin
          load    = 1'b1;
          busy_d  = 1'b1;
          state_d = (cfg_dst_len == '0) ? SCHED_FLUSH : SCHED_RUN;
        end
      end
      SCHED_RUN: begin
        // Issue whenever the output stage is empty or draining this cycle.
        issue = ~vld_q | coe.coe_ready;
        if (issue && pa_last) begin
          state_d = SCHED_FLUSH;
        end
      end
      SCHED_FLUSH: begin
        // An empty output stage here only happens for a zero-length line.
        if (!vld_q || (accept && last_q)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = SCHED_IDLE;
        end
      end
      default: state_d = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCHED_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Output stage: one cycle behind issue, matching the ROM read latency.
  // Holding the whole beat under backpressure keeps the ROM on the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      addr_q <= '0;
      adv_q  <= '0;
      last_q <= 1'b0;
    end else if (issue) begin
      vld_q  <= 1'b1;
      addr_q <= pa_addr;
      adv_q  <= pa_adv;
      last_q <= pa_last;
    end else if (accept) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign coe.coe_vld     = vld_q;
  assign coe.coe_addr    = addr_q;
  assign coe.coe_src_adv = adv_q;
  assign coe.coe_last    = last_q;

endmodule

// File: tb/tb_scaler_coe_sched.sv
// tb/tb_scaler_coe_sched.sv - directed self-checking bench for scaler_coe_sched

module tb_scaler_coe_sched;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] cfg_step;
  logic [11:0] cfg_dst_len;
  logic        busy;
  logic        done;

  int n_checks;
  int n_errors;
  int ea[8];
  int ed[8];

  scaler_coe_sched_if #(.AW(5), .ADV_W(5)) coe_if ();

  scaler_coe_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_step    (cfg_step),
    .cfg_dst_len (cfg_dst_len),
    .busy        (busy),
    .done        (done),
    .coe         (coe_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one line from a start pulse until done (bounded), checking each
  // accepted beat against ea/ed and the done latency in cycles after start.
  task automatic run_line(input string tag, input logic [15:0] step, input int len,
                          input int stall_beat, input int stall_cycles,
                          input int busy_start_c, input int exp_done_c);
    int c, nb, first_c, done_c, stall_left;
    int sa, sd, sl;
    @(negedge clk);
    start       = 1'b1;
    cfg_step    = step;
    cfg_dst_len = 12'(len);
    coe_if.coe_ready = 1'b1;
    c = 0; nb = 0; first_c = -1; done_c = -1; stall_left = stall_cycles;
    sa = 0; sd = 0; sl = 0;
    while (done_c < 0 && c < 60) begin
      @(negedge clk);
      c++;
      start = (c == busy_start_c);
      if (c == busy_start_c) begin
        cfg_step    = 16'h0800;
        cfg_dst_len = 12'd2;
      end
      if (c == 1) check_eq({tag, " busy"}, int'(busy), 1);
      if (coe_if.coe_vld) begin
        if (nb == stall_beat && stall_left > 0) begin
          if (stall_left == stall_cycles) begin
            sa = int'(coe_if.coe_addr); sd = int'(coe_if.coe_src_adv); sl = int'(coe_if.coe_last);
          end else begin
            check_eq({tag, " hold addr"}, int'(coe_if.coe_addr), sa);
            check_eq({tag, " hold adv"}, int'(coe_if.coe_src_adv), sd);
            check_eq({tag, " hold last"}, int'(coe_if.coe_last), sl);
          end
          coe_if.coe_ready = 1'b0;
          stall_left--;
        end else begin
          coe_if.coe_ready = 1'b1;
          if (first_c < 0) first_c = c;
          if (nb < 8) begin
            check_eq($sformatf("%s addr%0d", tag, nb), int'(coe_if.coe_addr), ea[nb]);
            check_eq($sformatf("%s adv%0d", tag, nb), int'(coe_if.coe_src_adv), ed[nb]);
            check_eq($sformatf("%s last%0d", tag, nb), int'(coe_if.coe_last), (nb == len - 1) ? 1 : 0);
          end
          nb++;
        end
      end else begin
        coe_if.coe_ready = 1'b1;
      end
      if (done) done_c = c;
    end
    start = 1'b0;
    coe_if.coe_ready = 1'b1;
    check_eq({tag, " beats"}, nb, len);
    check_eq({tag, " done cycle"}, done_c, exp_done_c);
    if (len > 0) check_eq({tag, " first beat cycle"}, first_c, 2);
    @(negedge clk);
    check_eq({tag, " done pulse"}, int'(done), 0);
    check_eq({tag, " idle busy"}, int'(busy), 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    cfg_step = '0;
    cfg_dst_len = '0;
    coe_if.coe_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("reset busy", int'(busy), 0);
    check_eq("reset done", int'(done), 0);
    check_eq("reset vld", int'(coe_if.coe_vld), 0);
    check_eq("reset addr", int'(coe_if.coe_addr), 0);
    check_eq("reset adv", int'(coe_if.coe_src_adv), 0);
    check_eq("reset last", int'(coe_if.coe_last), 0);

    ea = '{0, 0, 0, 0, 0, 0, 0, 0};  ed = '{1, 1, 1, 1, 0, 0, 0, 0};
    run_line("unity", 16'h1000, 4, -1, 0, -1, 6);

    ea = '{0, 16, 0, 16, 0, 0, 0, 0}; ed = '{0, 1, 0, 1, 0, 0, 0, 0};
    run_line("half", 16'h0800, 4, -1, 0, -1, 6);

    ea = '{0, 16, 0, 16, 0, 0, 0, 0}; ed = '{1, 2, 1, 2, 0, 0, 0, 0};
    run_line("x1p5", 16'h1800, 4, -1, 0, -1, 6);

    ea = '{0, 10, 21, 0, 0, 0, 0, 0}; ed = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_line("third", 16'h0555, 3, -1, 0, -1, 5);

    ea = '{0, 0, 0, 0, 0, 0, 0, 0};  ed = '{1, 1, 1, 1, 0, 0, 0, 0};
    run_line("stall", 16'h1000, 4, 1, 3, -1, 9);

    ea = '{0, 0, 0, 0, 0, 0, 0, 0};  ed = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_line("len0", 16'h1000, 0, -1, 0, -1, 2);

    ea = '{0, 0, 0, 0, 0, 0, 0, 0};  ed = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_line("step0", 16'h0000, 3, -1, 0, -1, 5);

    ea = '{0, 0, 0, 0, 0, 0, 0, 0};  ed = '{1, 1, 1, 1, 0, 0, 0, 0};
    run_line("start busy", 16'h1000, 4, -1, 0, 2, 6);

    // Reset while beat 1 (addr 16) of a half-step line is on the outputs.
    @(negedge clk);
    start = 1'b1; cfg_step = 16'h0800; cfg_dst_len = 12'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("pre-reset addr", int'(coe_if.coe_addr), 16);
    rst_n = 1'b0;
    #1;
    check_eq("mid reset vld", int'(coe_if.coe_vld), 0);
    check_eq("mid reset addr", int'(coe_if.coe_addr), 0);
    check_eq("mid reset adv", int'(coe_if.coe_src_adv), 0);
    check_eq("mid reset last", int'(coe_if.coe_last), 0);
    check_eq("mid reset busy", int'(busy), 0);
    check_eq("mid reset done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post reset done", int'(done), 0);

    ea = '{0, 16, 0, 16, 0, 0, 0, 0}; ed = '{0, 1, 0, 1, 0, 0, 0, 0};
    run_line("after reset", 16'h0800, 4, -1, 0, -1, 6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
